// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if: stereo sample valid/ready bundle into the I2S DAC
// transmitter. Master is the sample source, slave the serialiser.
interface i2s_dac_tx_if #(
  parameter int SAMPLE_LENGTH = 24
);
  logic [SAMPLE_LENGTH-1:0] s_left;
  logic [SAMPLE_LENGTH-1:0] s_right;
  logic                     s_valid;
  logic                     s_ready;

  modport master (
    output s_left, s_right, s_valid,
    input  s_ready
  );

  modport slave (
    input  s_left, s_right, s_valid,
    output s_ready
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S DAC serialiser, codec-mastered BCLK/LRC sampled in MCLK.
// Define TX_HOLD_ON_UNDERRUN_EN to repeat the last pair on underrun.
module i2s_dac_tx #(
  parameter int SAMPLE_LENGTH = 24,
  parameter int MAX_SLOT_BITS = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        MCLK,
  input  logic        AUD_ADCLRCK,
  input  logic        AUD_BCLK,
  input  logic        AUD_DACLRCK,
  i2s_dac_tx_if.slave s,
  output logic        AUD_DACDAT,
  output logic        frame_start,
  output logic        underrun
);

  localparam int CW = $clog2(MAX_SLOT_BITS) + 1;
  localparam logic [CW-1:0] SL_C  = CW'(SAMPLE_LENGTH);
  localparam logic [CW-1:0] SAT_C = CW'(MAX_SLOT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, ARM_L, ARM_R, SHIFT
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   bclk_sync_q;
  logic [SYNC_STAGES-1:0]   lrc_sync_q;
  logic                     bclk_last_q;
  logic                     lrc_prev_q;
  logic                     full_q;
  logic [SAMPLE_LENGTH-1:0] buf_l_q;
  logic [SAMPLE_LENGTH-1:0] buf_r_q;
  logic [SAMPLE_LENGTH-1:0] act_l_q;
  logic [SAMPLE_LENGTH-1:0] act_r_q;
  logic [SAMPLE_LENGTH-1:0] sh_q;
  logic [CW-1:0]            bitcnt_q;
  logic                     dat_q;
  logic                     fs_q;
  logic                     ur_q;

  logic                     bclk_s;
  logic                     lrc_s;
  logic                     bclk_fall;
  logic                     lrc_left;
  logic                     lrc_right;
  logic                     enter_l;
  logic [SAMPLE_LENGTH-1:0] arm_word;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrc_s     = lrc_sync_q[SYNC_STAGES-1];
  assign bclk_fall = bclk_last_q & ~bclk_s;
  assign lrc_left  = lrc_prev_q & ~lrc_s;
  assign lrc_right = ~lrc_prev_q & lrc_s;
  assign enter_l   = bclk_fall & lrc_left &
                     ((state_q == WAIT) | (state_q == SHIFT));
  assign arm_word  = (state_q == ARM_R) ? act_r_q : act_l_q;

  assign s.s_ready   = ~full_q;
  assign AUD_DACDAT  = dat_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

  always_ff @(posedge MCLK or negedge AUD_ADCLRCK) begin
    if (!AUD_ADCLRCK) begin
      state_q     <= IDLE;
      bclk_sync_q <= '0;
      lrc_sync_q  <= '0;
      bclk_last_q <= 1'b0;
      lrc_prev_q  <= 1'b0;
      full_q      <= 1'b0;
      buf_l_q     <= '0;
      buf_r_q     <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      sh_q        <= '0;
      bitcnt_q    <= '0;
      dat_q       <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      bclk_sync_q[0] <= AUD_BCLK;
      lrc_sync_q[0]  <= AUD_DACLRCK;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync_q[i] <= bclk_sync_q[i-1];
        lrc_sync_q[i]  <= lrc_sync_q[i-1];
      end
      bclk_last_q <= bclk_s;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;

      if (s.s_valid && !full_q) begin
        buf_l_q <= s.s_left;
        buf_r_q <= s.s_right;
        full_q  <= 1'b1;
      end

      // Left-slot start: consume the buffered pair or flag underrun
      if (enter_l) begin
        fs_q <= 1'b1;
        if (full_q) begin
          act_l_q <= buf_l_q;
          act_r_q <= buf_r_q;
          full_q  <= 1'b0;
        end else begin
          ur_q <= 1'b1;
`ifdef TX_HOLD_ON_UNDERRUN_EN
          act_l_q <= act_l_q;
          act_r_q <= act_r_q;
`else
          act_l_q <= '0;
          act_r_q <= '0;
`endif
        end
      end

      if (bclk_fall) begin
        lrc_prev_q <= lrc_s;
        unique case (state_q)
          IDLE: state_q <= WAIT;
          WAIT: begin
            dat_q <= 1'b0;
            if (lrc_left) state_q <= ARM_L;
          end
          ARM_L, ARM_R: begin
            dat_q    <= arm_word[SAMPLE_LENGTH-1];
            sh_q     <= {arm_word[SAMPLE_LENGTH-2:0], 1'b0};
            bitcnt_q <= CW'(1);
            state_q  <= SHIFT;
          end
          SHIFT: begin
            // The bit on a slot-ending edge still belongs to this word
            if (bitcnt_q < SL_C) begin
              dat_q <= sh_q[SAMPLE_LENGTH-1];
              sh_q  <= sh_q << 1;
            end else begin
              dat_q <= 1'b0;
            end
            if (bitcnt_q != SAT_C) bitcnt_q <= bitcnt_q + CW'(1);
            if (lrc_left)       state_q <= ARM_L;
            else if (lrc_right) state_q <= ARM_R;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: codec-side model driving BCLK/LRC and capturing DACDAT
// at BCLK rise; directed frames checked against hand-computed words.
module tb_i2s_dac_tx;

  logic MCLK        = 1'b0;
  logic rst_n       = 1'b0;
  logic AUD_BCLK    = 1'b1;
  logic AUD_DACLRCK = 1'b1;
  logic AUD_DACDAT;
  logic frame_start;
  logic underrun;

  i2s_dac_tx_if sif ();

  i2s_dac_tx dut (
    .MCLK        (MCLK),
    .AUD_ADCLRCK (rst_n),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .s           (sif),
    .AUD_DACDAT  (AUD_DACDAT),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #10 MCLK = ~MCLK;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] cl;
    logic [31:0] cr;
  } vec_t;

  vec_t        vecs [4];
  int          checks = 0;
  int          errors = 0;
  int          slot_bits = 32;
  int          fs_cnt = 0;
  int          ur_cnt = 0;
  int          hi_cnt = 0;
  bit          bp_on = 1'b0;
  logic [31:0] caps [$];
  logic [47:0] acc_q [$];

  // Codec master: LRC toggles with the first BCLK fall of each slot
  initial begin : codec
    int n;
    logic [31:0] c;
    #3;
    forever begin
      n = slot_bits;
      c = '0;
      for (int i = 0; i < n; i++) begin
        AUD_BCLK = 1'b0;
        if (i == 0) AUD_DACLRCK = ~AUD_DACLRCK;
        #160;
        AUD_BCLK = 1'b1;
        c = {c[30:0], AUD_DACDAT};
        #160;
      end
      caps.push_back(c);
    end
  end

  always @(negedge MCLK) begin
    if (frame_start === 1'b1) fs_cnt++;
    if (underrun === 1'b1) ur_cnt++;
    if (AUD_DACDAT === 1'b1) hi_cnt++;
    if (sif.s_valid === 1'b1 && sif.s_ready === 1'b1)
      acc_q.push_back({sif.s_left, sif.s_right});
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic wait_fs(input string nm);
    int b = fs_cnt;
    int t = 0;
    while (fs_cnt == b && t < 4000) begin
      @(negedge MCLK);
      t++;
    end
    if (fs_cnt == b) tmo({nm, " frame_start"});
  endtask

  task automatic wait_caps(input int n, input string nm);
    int t = 0;
    while (caps.size() < n && t < 6000) begin
      @(negedge MCLK);
      t++;
    end
    if (caps.size() < n) tmo({nm, " capture"});
  endtask

  task automatic feed(input logic [23:0] l, input logic [23:0] r,
                      input string nm);
    int t = 0;
    #2000;
    @(posedge MCLK);
    #1;
    sif.s_left  = l;
    sif.s_right = r;
    sif.s_valid = 1'b1;
    while (t < 4000) begin
      @(negedge MCLK);
      if (sif.s_ready) break;
      t++;
    end
    if (t >= 4000) tmo({nm, " accept"});
    @(posedge MCLK);
    #1;
    sif.s_valid = 1'b0;
    @(negedge MCLK);
    chk({nm, " s_ready after accept"}, 32'(sif.s_ready), 32'd0);
  endtask

  task automatic check32(input logic [31:0] cl, input logic [31:0] cr,
                         input string nm);
    int bf = fs_cnt;
    int bu = ur_cnt;
    int n;
    wait_fs(nm);
    chk({nm, " s_ready at left start"}, 32'(sif.s_ready), 32'd1);
    n = caps.size();
    wait_caps(n + 2, nm);
    chk({nm, " left word"}, caps[n], cl);
    chk({nm, " right word"}, caps[n+1], cr);
    chk({nm, " frame_start count"}, 32'(fs_cnt - bf), 32'd1);
    chk({nm, " no underrun"}, 32'(ur_cnt - bu), 32'd0);
  endtask

  task automatic check16(input logic [23:0] l, input logic [23:0] r,
                         input string nm);
    int n;
    wait_fs(nm);
    n = caps.size();
    wait_caps(n + 3, nm);
    chk({nm, " left top15"}, 32'(caps[n][14:0]), 32'(l[23:9]));
    chk({nm, " left bit8"}, 32'(caps[n+1][15]), 32'(l[8]));
    chk({nm, " right top15"}, 32'(caps[n+1][14:0]), 32'(r[23:9]));
    chk({nm, " right bit8"}, 32'(caps[n+2][15]), 32'(r[8]));
  endtask

  initial begin : main
    int hb;
    int fb;
    int n;
    logic [31:0] el;
    logic [31:0] er;
    logic [23:0] v;

    vecs[0] = '{24'hA50F3C, 24'h800001, 32'h52879E00, 32'h40000080};
    vecs[1] = '{24'h7FFFFF, 24'h000001, 32'h3FFFFF80, 32'h00000080};
    vecs[2] = '{24'h000000, 24'h5A5A5A, 32'h00000000, 32'h2D2D2D00};
    vecs[3] = '{24'hFFFFFF, 24'h123456, 32'h7FFFFF80, 32'h091A2B00};

    sif.s_left  = '0;
    sif.s_right = '0;
    sif.s_valid = 1'b0;

    // Start-up: release reset in the middle of a right slot
    @(posedge AUD_DACLRCK);
    #1000;
    @(negedge MCLK);
    chk("reset DACDAT", 32'(AUD_DACDAT), 32'd0);
    chk("reset s_ready", 32'(sif.s_ready), 32'd1);
    chk("reset frame_start", 32'(frame_start), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    @(posedge MCLK);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      feed(vecs[i].l, vecs[i].r, $sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge AUD_DACLRCK);
        chk("startup no frame_start", 32'(fs_cnt), 32'd0);
        chk("startup no data", 32'(hi_cnt), 32'd0);
      end
      check32(vecs[i].cl, vecs[i].cr, $sformatf("vec%0d", i));
    end

`ifdef TX_HOLD_ON_UNDERRUN_EN
    el = vecs[3].cl;
    er = vecs[3].cr;
`else
    el = '0;
    er = '0;
`endif
    hb = hi_cnt;
    for (int k = 0; k < 3; k++) begin
      fb = ur_cnt;
      wait_fs("underrun");
      chk($sformatf("underrun pulse %0d", k), 32'(ur_cnt - fb), 32'd1);
      n = caps.size();
      wait_caps(n + 2, "underrun");
      chk($sformatf("underrun left %0d", k), caps[n], el);
      chk($sformatf("underrun right %0d", k), caps[n+1], er);
    end
`ifndef TX_HOLD_ON_UNDERRUN_EN
    chk("underrun DACDAT silent", 32'(hi_cnt - hb), 32'd0);
`endif

    // Back-pressure: fresh data every cycle, one accept per frame
    #2000;
    acc_q.delete();
    @(posedge MCLK);
    #1;
    bp_on = 1'b1;
    fork
      begin : bp
        v = 24'h100000;
        while (bp_on) begin
          sif.s_left  = v;
          sif.s_right = ~v;
          sif.s_valid = 1'b1;
          v = v + 24'h010203;
          @(posedge MCLK);
          #1;
        end
        sif.s_valid = 1'b0;
      end
    join_none
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bp_on = 1'b0;
      wait_fs("bp");
      n = caps.size();
      wait_caps(n + 2, "bp");
      el = {1'b0, acc_q[k][47:24], 7'b0};
      er = {1'b0, acc_q[k][23:0], 7'b0};
      chk($sformatf("bp left %0d", k), caps[n], el);
      chk($sformatf("bp right %0d", k), caps[n+1], er);
    end
    chk("bp accept count", 32'(acc_q.size()), 32'd5);

    // Short slots: 16 BCLK per LRC half
    slot_bits = 16;
    feed(24'hC3A5F0, 24'h5A0F81, "short0");
    check16(24'hC3A5F0, 24'h5A0F81, "short0");
    feed(24'h3C5A01, 24'hE1F1FF, "short1");
    check16(24'h3C5A01, 24'hE1F1FF, "short1");

    // Reset at bit 10 of a right slot with a pair still buffered
    slot_bits = 32;
    wait_fs("resync");
    feed(24'hABCDEF, 24'hFFFFFF, "rst_r1");
    wait_fs("rst_r1");
    feed(24'h111111, 24'h222222, "rst_x");
    @(posedge AUD_DACLRCK);
    hb = hi_cnt;
    repeat (10) @(posedge AUD_BCLK);
    chk("rst data mid-slot", 32'(hi_cnt > hb), 32'd1);
    @(posedge MCLK);
    #1;
    rst_n = 1'b0;
    @(negedge MCLK);
    chk("rst DACDAT", 32'(AUD_DACDAT), 32'd0);
    chk("rst s_ready", 32'(sif.s_ready), 32'd1);
    repeat (4) @(posedge MCLK);
    #1;
    rst_n = 1'b1;
    hb = hi_cnt;
    fb = fs_cnt;
    @(negedge AUD_DACLRCK);
    chk("post-rst silent", 32'(hi_cnt - hb), 32'd0);
    chk("post-rst no frame_start", 32'(fs_cnt - fb), 32'd0);
    n = caps.size();
    feed(24'h5EED01, 24'h0BEEF0, "rst_y");
    check32(32'h2F768080, 32'h05F77800, "rst_y");
    chk("rst buffer dropped left", caps[n], 32'd0);
    chk("rst buffer dropped right", caps[n+1], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
